// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared definitions for the iterative arithmetic engines.
//   state_t       : IDLE / CALC / FIX sequencing states (also used by the
//                   sequential divider).
//   DEFAULT_WIDTH : default operand width.
package seq_shift_add_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shift_add_multiplier_twos_abs.sv
// Conditional two's-complement absolute value.
//   in  : WIDTH-bit operand
//   en  : 1 = treat in as signed and take its magnitude; 0 = pass through
//   out : magnitude (unsigned). The most negative value maps to
//         2^(WIDTH-1), which still fits in WIDTH unsigned bits.
module seq_shift_add_multiplier_twos_abs #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  output logic [WIDTH-1:0] out
);

  assign out = (en && in[WIDTH-1]) ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-and-add multiplier, one multiplier bit per clock.
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   start       : request a multiply (only looked at while idle)
//   signed_mode : 0 = unsigned operands, 1 = two's-complement operands
//   a, b        : multiplicand / multiplier, captured with start
//   busy        : high while an operation is in progress
//   done        : one-cycle pulse when product is updated
//   product     : 2*WIDTH-bit result, held until the next completion
//
// Handshake: start is accepted on any rising edge where the engine is idle
// (including the cycle in which done is high). busy rises on that edge and
// falls on the edge that raises done; done and the new product appear
// WIDTH+1 edges after acceptance. Inputs are ignored while busy.
//
// Signed operation multiplies magnitudes and applies the sign at the end,
// so the core datapath is always unsigned.
module seq_shift_add_multiplier
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state, state_next;

  logic [PW:0]       acc;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  mcand;
  logic              neg;

  logic [WIDTH-1:0]  abs_a, abs_b;
  logic [WIDTH:0]    upper_next;

  seq_shift_add_multiplier_twos_abs #(.WIDTH(WIDTH)) u_abs_a (
    .in  (a),
    .en  (signed_mode),
    .out (abs_a)
  );

  seq_shift_add_multiplier_twos_abs #(.WIDTH(WIDTH)) u_abs_b (
    .in  (b),
    .en  (signed_mode),
    .out (abs_b)
  );

  // Upper half plus carry-out after the conditional add of this step.
  always_comb begin
    upper_next = {1'b0, acc[PW-1:WIDTH]};
    if (acc[0]) begin
      upper_next = {1'b0, acc[PW-1:WIDTH]} + {1'b0, mcand};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_CALC;
      ST_CALC: if (cnt == CNT_LAST) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      mcand   <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            mcand <= abs_a;
            acc   <= {1'b0, {WIDTH{1'b0}}, abs_b};
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_CALC: begin
          // Add and shift in one step: the carry lands in the top bit and
          // the consumed multiplier bit drops off the bottom.
          acc <= {1'b0, upper_next, acc[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
        end
        ST_FIX: begin
          product <= neg ? (~acc[PW-1:0] + PW'(1)) : acc[PW-1:0];
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier at WIDTH=8.
module tb_seq_shift_add_multiplier;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks   = 0;
  int failures = 0;

  logic [2*W-1:0] exp_q[$];

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done after the accepting edge. Returns the number of
  // edges to done and the number of sampled busy cycles. With noise set,
  // stray start pulses and operand changes are driven while busy.
  task automatic wait_done(input bit noise, output int lat, output int busy_n);
    bit got;
    got    = 1'b0;
    lat    = 0;
    busy_n = busy ? 1 : 0;
    while (lat < 20 && !got) begin
      if (noise) begin
        start = (lat < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
        a     = W'($urandom_range(0, 255));
        b     = W'($urandom_range(0, 255));
        signed_mode = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
      if (done) got = 1'b1;
      else if (busy) busy_n++;
    end
  endtask

  // Scoreboard: pop the oldest expected product on done.
  task automatic score(input string tag);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_prod"}, 32'(product), 32'(e));
    end
  endtask

  // One isolated multiply; caller is just after a rising edge.
  task automatic run_op(input string tag, input logic mode, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic [2*W-1:0] exp);
    int lat, busy_n;
    exp_q.push_back(exp);
    signed_mode = mode;
    a           = va;
    b           = vb;
    start       = 1'b1;
    tick();
    wait_done(1'b1, lat, busy_n);
    start = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'd9);
    check({tag, "_busy"}, 32'(busy_n), 32'd9);
    score(tag);
    tick();
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(product), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, busy_n;
    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_prod", 32'(product), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    run_op("u13x11", 1'b0, 8'd13, 8'd11, 16'h008F);
    run_op("umax",   1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run_op("sm1xm1", 1'b1, 8'hFF, 8'hFF, 16'h0001);
    run_op("sm3x5",  1'b1, 8'hFD, 8'h05, 16'hFFF1);
    run_op("smin2",  1'b1, 8'h80, 8'h80, 16'h4000);
    run_op("sminx1", 1'b1, 8'h80, 8'h01, 16'hFF80);

    // Idle: no start, nothing moves.
    repeat (5) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_prod", 32'(product), 32'h0000FF80);

    // Back-to-back with start held high.
    exp_q.push_back(16'h002A);
    exp_q.push_back(16'h0051);
    signed_mode = 1'b0;
    a = 8'd7;
    b = 8'd6;
    start = 1'b1;
    tick();
    check("b2b_busy1", 32'(busy), 32'd1);
    a = 8'd9;
    b = 8'd9;
    wait_done(1'b0, lat, busy_n);
    check("b2b_lat1", 32'(lat), 32'd9);
    score("b2b1");
    tick();
    check("b2b_accept", 32'(busy), 32'd1);
    check("b2b_done_lo", 32'(done), 32'd0);
    start = 1'b0;
    a = 8'd1;
    b = 8'd1;
    wait_done(1'b0, lat, busy_n);
    check("b2b_lat2", 32'(lat), 32'd9);
    score("b2b2");
    tick();

    // Reset in the middle of CALC.
    signed_mode = 1'b0;
    a = 8'h55;
    b = 8'h33;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("mid_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_prod", 32'(product), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    check("abort_no_done", 32'(done), 32'd0);
    run_op("u3x4", 1'b0, 8'd3, 8'd4, 16'h000C);

    run_op("s0xab", 1'b1, 8'h00, 8'hAB, 16'h0000);

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Parametrised iterative shift-and-add multiplier. It multiplies two WIDTH-bit operands in either unsigned or two's-complement signed mode, retiring one multiplier bit per clock.
- It uses a start/busy/done handshake and holds its result between operations.
- It is the general-purpose multiply engine for datapaths that can spend WIDTH+2 cycles to avoid a combinational array multiplier.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request a multiply; sampled only in IDLE.
- signed_mode  input  1  0 = unsigned operands; 1 = two's-complement operands. Sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when product is updated.
- product  output  2*WIDTH  result; held until the next completion.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal accumulator and counter cleared.
  - Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, CALC, FIX. State encoding is local to the module.
- IDLE:
  - done is driven 0 on every edge unless FIX is completing.
  - On an edge with start=1:
    - Latch neg = signed_mode & (a[W-1] ^ b[W-1]).
    - Latch mcand = |a| and mplr = |b|. Absolute value applies only when signed_mode=1 and the MSB is set; otherwise the raw value is used. |-2^(W-1)| = 2^(W-1) fits in WIDTH unsigned bits.
    - Load acc = {1'b0 carry, WIDTH zeros, mplr}; cnt=0; busy<=1; go to CALC.
- CALC, one edge per multiplier bit:
  - If acc[0]=1, add mcand to upper WIDTH bits with carry into bit 2W.
  - Then shift the whole (2W+1)-bit acc right by 1, with zero fill.
  - Add and shift happen in the same cycle.
  - cnt increments; after the edge with cnt=WIDTH-1, go to FIX.
- FIX:
  - product <= neg ? (~acc[2W-1:0] + 1) : acc[2W-1:0].
  - done<=1, busy<=0, go to IDLE.
- Latency:
  - start sampled at edge k; busy high from edge k.
  - product/done are valid after edge k+WIDTH+1; done is high for exactly that one cycle.
  - Throughput is one result per WIDTH+2 cycles.
- Boundary rules:
  - start while busy is ignored; operand changes while busy have no effect.
  - start high in the cycle done is high is accepted (state is IDLE), giving back-to-back operation.
  - Zero operands run the full WIDTH cycles; there is no early exit.
  - Full range is covered without overflow:
    - Unsigned max (2^W-1)^2 fits in 2W bits.
    - Signed (-2^(W-1))^2 = 2^(2W-2) fits in 2W signed bits.
  - Signed zero result with neg=1: negation of 0 yields 0.
  - product is not modified by an aborted or ignored request.

Decomposition:
- Shared package: state encoding constants (IDLE/CALC/FIX) and the WIDTH default. This lets the sibling sequential divider reuse them.
- One natural combinational sub-module: twos_abs (WIDTH param; in, en, out = en&in[MSB] ? -in : in). It is instantiated twice for a and b; the FIX negation is done inline.
- The remainder is a single sequential block.

Test Plan (WIDTH=8):
- Unsigned: signed_mode=0, a=13, b=11, start pulse.
  - Required: busy for 9 cycles; done one cycle at start+9 edges; product=0x008F (143).
- Unsigned max: a=0xFF, b=0xFF, mode 0 → product=0xFE01.
  - Same bits in mode 1 (-1 × -1) → product=0x0001.
- Signed mixed: mode 1, a=0xFD (-3), b=0x05 → product=0xFFF1 (-15).
  - a=0x80, b=0x80 → product=0x4000.
  - a=0x80, b=0x01 → product=0xFF80.
- Handshake: start held high continuously across two operations (7×6 then 9×9).
  - Second operation is accepted on the done cycle.
  - Results are 0x002A then 0x0051.
  - Operand changes during busy are ignored.
- Reset mid-operation: assert rst_n=0 at cycle 4 of CALC.
  - Required: busy=0, done=0, product=0 immediately (async).
  - After release, a new 3×4 completes with product=0x000C.
- Zero/idle: a=0, b=0xAB in mode 1 → product=0x0000, done still at 9 edges.
  - With no start, done and busy stay 0 and product holds its previous value.
